// File: rtl/slc3_pkg.sv
// rtl/slc3_pkg.sv - shared SLC-3 datapath types and widths
package slc3_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - access timeout counter, used by mem_access_ctrl under MEM_TIMEOUT_EN
module mem_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= 8'd0;
    end else if (clear) begin
      cnt <= 8'd0;
    end else if (tick) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Fires during the TIMEOUT-th ack-less cycle so DONE follows it directly.
  assign expired = tick && (cnt == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - SLC-3 MAR/MDR owner and SRAM handshake FSM; MEM_TIMEOUT_EN adds access abort
module mem_access_ctrl
  import slc3_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] bus,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic              mem_req,
  input  logic              mem_we,
  output logic [WORD_W-1:0] mar,
  output logic [WORD_W-1:0] mdr,
  output logic              mem_ready,
  output logic              mem_err,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [WORD_W-1:0] sram_addr,
  output logic [WORD_W-1:0] sram_wdata,
  input  logic [WORD_W-1:0] sram_rdata,
  input  logic              sram_ack
);

  mem_state_t state;
  logic       we_q;

`ifdef MEM_TIMEOUT_EN
  logic err_q;
  logic expired;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state == IDLE && mem_req),
    .tick    (state == ACCESS && !sram_ack),
    .expired (expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      mar   <= '0;
      mdr   <= '0;
      we_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      err_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ld_mar) mar <= bus;
          if (ld_mdr) mdr <= bus;
          if (mem_req) begin
            we_q  <= mem_we;
            state <= ACCESS;
`ifdef MEM_TIMEOUT_EN
            err_q <= 1'b0;
`endif
          end
        end
        ACCESS: begin
          // An ack in the expiring cycle still counts as a normal completion.
          if (sram_ack) begin
            if (!we_q) mdr <= sram_rdata;
            state <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (expired) begin
            err_q <= 1'b1;
            state <= DONE;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_ready  = (state == DONE);
  assign sram_ce    = (state == ACCESS);
  assign sram_we    = (state == ACCESS) && we_q;
  assign sram_addr  = mar;
  assign sram_wdata = mdr;
`ifdef MEM_TIMEOUT_EN
  assign mem_err    = (state == DONE) && err_q;
`else
  assign mem_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - table-driven bench for mem_access_ctrl, timeout cases under MEM_TIMEOUT_EN
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] bus;
  logic        ld_mar, ld_mdr, mem_req, mem_we;
  logic [15:0] mar, mdr;
  logic        mem_ready, mem_err, sram_ce, sram_we;
  logic [15:0] sram_addr, sram_wdata, sram_rdata;
  logic        sram_ack;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .ld_mar     (ld_mar),
    .ld_mdr     (ld_mdr),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mar        (mar),
    .mdr        (mdr),
    .mem_ready  (mem_ready),
    .mem_err    (mem_err),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_ack   (sram_ack)
  );

  typedef struct {
    logic        rst_n, ld_mar, ld_mdr, req, we, ack;
    logic [15:0] bus, rdata;
    logic [15:0] e_mar, e_mdr;
    logic        e_rdy, e_err, e_ce, e_we;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input int idx, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset_n = 1'b1; ld_mar = 1'b0; ld_mdr = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    sram_ack = 1'b0; bus = 16'h0; sram_rdata = 16'h0;
  endtask

  initial begin
    logic exp_rdy[6];
    //           rst ldA ldD req we ack bus       rdata      e_mar     e_mdr    rdy err ce we
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0};
    vecs[2]  = '{1, 1, 0, 0, 0, 0, 16'h3000, 16'h0000, 16'h3000, 16'h0000, 0, 0, 0, 0};
    vecs[3]  = '{1, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h3000, 16'h0000, 0, 0, 1, 0};
    vecs[4]  = '{1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h3000, 16'h0000, 0, 0, 1, 0};
    vecs[5]  = '{1, 1, 1, 1, 0, 0, 16'hFFFF, 16'h0000, 16'h3000, 16'h0000, 0, 0, 1, 0};
    vecs[6]  = '{1, 0, 0, 0, 0, 1, 16'h0000, 16'hBEEF, 16'h3000, 16'hBEEF, 1, 0, 0, 0};
    vecs[7]  = '{1, 0, 0, 0, 0, 1, 16'h0000, 16'h1111, 16'h3000, 16'hBEEF, 0, 0, 0, 0};
    vecs[8]  = '{1, 1, 1, 0, 0, 0, 16'h0042, 16'h0000, 16'h0042, 16'h0042, 0, 0, 0, 0};
    vecs[9]  = '{1, 0, 1, 1, 1, 0, 16'h1234, 16'h0000, 16'h0042, 16'h1234, 0, 0, 1, 1};
    vecs[10] = '{1, 0, 0, 0, 0, 1, 16'h0000, 16'hDEAD, 16'h0042, 16'h1234, 1, 0, 0, 0};
    vecs[11] = '{1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0042, 16'h1234, 0, 0, 0, 0};
    vecs[12] = '{1, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0042, 16'h1234, 0, 0, 1, 0};
    vecs[13] = '{0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0};
    vecs[14] = '{1, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0};

    idle_inputs();
    reset_n = 1'b0;

    for (int i = 0; i < 15; i++) begin
      reset_n = vecs[i].rst_n;   ld_mar = vecs[i].ld_mar; ld_mdr = vecs[i].ld_mdr;
      mem_req = vecs[i].req;     mem_we = vecs[i].we;     sram_ack = vecs[i].ack;
      bus = vecs[i].bus;         sram_rdata = vecs[i].rdata;
      step();
      chk("mar",        i, mar,               vecs[i].e_mar);
      chk("mdr",        i, mdr,               vecs[i].e_mdr);
      chk("sram_addr",  i, sram_addr,         vecs[i].e_mar);
      chk("sram_wdata", i, sram_wdata,        vecs[i].e_mdr);
      chk("mem_ready",  i, 16'(mem_ready),    16'(vecs[i].e_rdy));
      chk("mem_err",    i, 16'(mem_err),      16'(vecs[i].e_err));
      chk("sram_ce",    i, 16'(sram_ce),      16'(vecs[i].e_ce));
      chk("sram_we",    i, 16'(sram_we),      16'(vecs[i].e_we));
    end

    // mem_req held through DONE: second access starts from the IDLE cycle
    idle_inputs();
    ld_mar = 1'b1; bus = 16'h0100;
    step();
    ld_mar = 1'b0; mem_req = 1'b1; sram_ack = 1'b1; sram_rdata = 16'hAAAA;
    exp_rdy = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin ld_mar = 1'b1; ld_mdr = 1'b1; bus = 16'hFFFF; end
      else begin ld_mar = 1'b0; ld_mdr = 1'b0; end
      step();
      chk("b2b_ready", 100 + k, 16'(mem_ready), 16'(exp_rdy[k]));
    end
    chk("b2b_mar", 106, mar, 16'h0100);
    chk("b2b_mdr", 107, mdr, 16'hAAAA);
    idle_inputs();
    step();

`ifdef MEM_TIMEOUT_EN
    // no ack: abort after the 4th ACCESS cycle
    mem_req = 1'b1;
    step();
    mem_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("to_ce", 200 + k, 16'(sram_ce), 16'h1);
      chk("to_ready_early", 200 + k, 16'(mem_ready), 16'h0);
    end
    step();
    chk("to_ready", 210, 16'(mem_ready), 16'h1);
    chk("to_err",   211, 16'(mem_err),   16'h1);
    chk("to_mdr",   212, mdr,            16'hAAAA);
    step();
    chk("to_err_clr", 213, 16'(mem_err), 16'h0);

    // ack in the 4th cycle wins over the timeout
    mem_req = 1'b1;
    step();
    mem_req = 1'b0;
    for (int k = 0; k < 3; k++) step();
    sram_ack = 1'b1; sram_rdata = 16'h7777;
    step();
    sram_ack = 1'b0;
    chk("ack_win_ready", 220, 16'(mem_ready), 16'h1);
    chk("ack_win_err",   221, 16'(mem_err),   16'h0);
    chk("ack_win_mdr",   222, mdr,            16'h7777);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory access controller for the SLC-3 datapath. It owns the MAR and MDR registers and runs the SRAM read/write handshake. MAR and MDR load from the 16-bit CPU bus. The registered `mar` and `mdr` outputs feed the bus gating mux as its MAR/MDR sources. The control FSM issues `mem_req` and waits for a one-cycle `mem_ready` pulse.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum ACCESS cycles before abort; used only when the timeout feature is compiled in. Legal range 1..255.

Ports:
- `clk`  in  1  — single system clock; all state updates on its rising edge.
- `reset_n`  in  1  — reset, synchronous, active-low.
- `bus`  in  16  — CPU bus value; the source for MAR/MDR loads.
- `ld_mar`  in  1  — load `bus` into MAR.
- `ld_mdr`  in  1  — load `bus` into MDR.
- `mem_req`  in  1  — start a memory access.
- `mem_we`  in  1  — access type, sampled with `mem_req`: 1 = write, 0 = read.
- `mar`  out  16  — MAR register contents.
- `mdr`  out  16  — MDR register contents.
- `mem_ready`  out  1  — one-cycle pulse marking access completion.
- `mem_err`  out  1  — one-cycle pulse, coincident with `mem_ready`, marking an aborted access.
- `sram_ce`  out  1  — SRAM chip enable.
- `sram_we`  out  1  — SRAM write enable.
- `sram_addr`  out  16  — SRAM address; equals `mar`.
- `sram_wdata`  out  16  — SRAM write data; equals `mdr`.
- `sram_rdata`  in  16  — SRAM read data; valid when `sram_ack` = 1.
- `sram_ack`  in  1  — SRAM completion strobe.

## Operation
- FSM states: IDLE, ACCESS, DONE. Encoding is defined in the package.
- **IDLE**
  - `ld_mar`=1 → MAR ← `bus`.
  - `ld_mdr`=1 → MDR ← `bus`.
  - Both may be asserted in the same cycle.
  - `mem_req`=1 → latch `mem_we` into `we_q`; next state ACCESS.
  - A load and `mem_req` in the same cycle: the load takes effect, and the access uses the newly loaded MAR/MDR.
- **ACCESS**
  - Outputs: `sram_ce`=1, `sram_we`=`we_q`.
  - `sram_ack`=1 on a read → MDR ← `sram_rdata`; next state DONE.
  - `sram_ack`=1 on a write → MDR unchanged; next state DONE.
  - `ld_mar`, `ld_mdr` and `mem_req` are ignored, so MAR/MDR stay stable for the whole access.
- **DONE**
  - `mem_ready`=1 for exactly one cycle; next state is always IDLE.
  - `ld_mar`/`ld_mdr` are ignored.
  - `mem_req` is not sampled here. If it is still high in the following IDLE cycle, a new access starts; the control FSM must drop it in DONE.
- `sram_ack` in IDLE or DONE is ignored.
- `sram_ce` and `sram_we` are 0 outside ACCESS.

## Timing
- Reset (`reset_n`=0 at a clock edge):
  - state = IDLE; MAR = 0; MDR = 0; `we_q` = 0.
  - `mem_ready`, `mem_err`, `sram_ce`, `sram_we` = 0.
  - `sram_addr` and `sram_wdata` = 0, since they follow MAR/MDR.
- Reset mid-access: the access is abandoned immediately, with no `mem_ready`. `sram_ce` drops in the cycle after the reset edge.
- Register outputs: `mar` and `mdr` are registered and update on the edge after a load.
- FSM outputs: `mem_ready`, `mem_err`, `sram_ce` and `sram_we` are decoded combinationally from state.
- Latency, with `mem_req` sampled at edge E0:
  - ACCESS occupies the cycle after E0.
  - `sram_ack` sampled at edge E(k) → DONE occupies the cycle after E(k).
  - Minimum request-to-`mem_ready` latency is 2 cycles (ack present in the first ACCESS cycle).
  - On a read, MDR holds the read data in the DONE cycle.

## Configuration
- Macro: `MEM_TIMEOUT_EN`.
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments on each ACCESS cycle without `sram_ack`.
  - After `TIMEOUT` such cycles, the FSM goes to DONE with `mem_err`=1 and `mem_ready`=1. MDR is unchanged.
  - `sram_ack` arriving in the same cycle the count reaches `TIMEOUT` wins: normal completion, `mem_err`=0.
- Undefined: no counter; ACCESS waits for `sram_ack` indefinitely; `mem_err` is tied to 0.

## Structure
- Shared package `slc3_pkg`:
  - `WORD_W` = 16.
  - `mem_state_t` enum {IDLE, ACCESS, DONE}.
- One sub-module, `mem_timeout_ctr`: the counter plus `expired` compare. Instantiated only under `MEM_TIMEOUT_EN`.

## Test plan
- Reset, then idle: `mar`=0, `mdr`=0, `sram_ce`=0, `mem_ready`=0.
- Read: `ld_mar` with bus=16'h3000, then `mem_req` with `mem_we`=0; ack after 3 ACCESS cycles with rdata=16'hBEEF → `sram_addr`=16'h3000 throughout ACCESS; `mdr`=16'hBEEF; one `mem_ready` pulse.
- Write: MAR=16'h0042, `ld_mdr` with bus=16'h1234 asserted together with `mem_req`, `mem_we`=1 → `sram_wdata`=16'h1234, `sram_we`=1 during ACCESS; MDR unchanged after ack.
- Busy lockout: `ld_mar` with bus=16'hFFFF during ACCESS → `mar` unchanged; `reset_n` low during ACCESS → IDLE, no `mem_ready` pulse.
- With `MEM_TIMEOUT_EN`, `TIMEOUT`=4, no ack → `mem_ready` and `mem_err` both high in the cycle after the 4th ACCESS cycle; with ack in that 4th cycle → `mem_err`=0.
- `mem_req` held high through DONE → a second access starts from the IDLE cycle; back-to-back `mem_ready` pulses separated by at least 2 cycles.
